// File: rtl/regfile_rsp.sv
// regfile_rsp: 32 x 32-bit register file with a DEPTH-entry write-back buffer.
// Writes queue in a FIFO that drains one entry per cycle into the array
// unless stall is high. Reads are registered (1-cycle latency).
// Optional macro REGFILE_RSP_BYPASS_EN: reads forward the same-edge write and
// pending buffer entries. Without it, reads see array contents only.
module regfile_rsp #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rd_addr1,
  input  logic [31:0] rd_addr2,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        stall,
  output logic        wr_ready,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   r_regs     [32];
  logic [4:0]    r_buf_idx  [DEPTH];
  logic [31:0]   r_buf_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_rd_data1;
  logic [31:0]   r_rd_data2;
  logic          r_wr_ready;
  logic          r_busy;
  logic          r_overflow;

  logic [4:0]    w_idx1;
  logic [4:0]    w_idx2;
  logic [4:0]    w_widx;
  logic          w_aligned;
  logic          w_ready;
  logic          w_accept;
  logic          w_drop;
  logic          w_enq;
  logic          w_deq;
  logic [CW-1:0] w_count_n;
  logic [31:0]   w_rd1;
  logic [31:0]   w_rd2;
  logic          w_unused;

  assign w_idx1    = rd_addr1[6:2];
  assign w_idx2    = rd_addr2[6:2];
  assign w_widx    = wr_addr[6:2];
  assign w_aligned = (wr_addr[1:0] == 2'b00);
  // Acceptance is judged on the pre-edge count, so a full buffer drops even if it drains now
  assign w_ready   = (r_count < CW'(DEPTH));
  assign w_accept  = wr_en & w_aligned & w_ready;
  assign w_drop    = wr_en & w_aligned & ~w_ready;
  assign w_enq     = w_accept & (w_widx != 5'd0);
  assign w_deq     = (r_count != '0) & ~stall;
  assign w_count_n = CW'(r_count + CW'(w_enq) - CW'(w_deq));

  // Address bits outside [6:2] carry no register information
  assign w_unused  = ^{rd_addr1[31:7], rd_addr1[1:0], rd_addr2[31:7], rd_addr2[1:0], wr_addr[31:7]};

`ifdef REGFILE_RSP_BYPASS_EN
  // Same-edge write beats youngest pending entry, which beats the array
  function automatic logic [31:0] f_lookup(input logic [4:0] idx);
    logic [31:0]   v;
    logic [PW-1:0] pos;
    v = r_regs[idx];
    for (int k = 0; k < int'(DEPTH); k++) begin
      pos = PW'(r_head + PW'(k));
      if ((CW'(k) < r_count) && (r_buf_idx[pos] == idx)) v = r_buf_data[pos];
    end
    if (w_accept && (w_widx == idx)) v = wr_data;
    if (idx == 5'd0) v = 32'd0;
    return v;
  endfunction
`else
  // Array contents only; pending writes stay invisible until drained
  function automatic logic [31:0] f_lookup(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : r_regs[idx];
  endfunction
`endif

  // Read data selection for both ports
  always_comb begin
    w_rd1 = f_lookup(w_idx1);
    w_rd2 = f_lookup(w_idx2);
  end

  // Buffer payload storage; validity is tracked by r_count alone
  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      r_buf_idx[r_tail]  <= w_widx;
      r_buf_data[r_tail] <= wr_data;
    end
  end

  // Array, pointers, count and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rd_data1 <= 32'd0;
      r_rd_data2 <= 32'd0;
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_enq) r_tail <= PW'(r_tail + PW'(1));
      if (w_deq) begin
        r_regs[r_buf_idx[r_head]] <= r_buf_data[r_head];
        r_head                    <= PW'(r_head + PW'(1));
      end
      r_count    <= w_count_n;
      r_rd_data1 <= w_rd1;
      r_rd_data2 <= w_rd2;
      r_wr_ready <= (w_count_n < CW'(DEPTH));
      r_busy     <= (w_count_n != '0);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign rd_data1 = r_rd_data1;
  assign rd_data2 = r_rd_data2;
  assign wr_ready = r_wr_ready;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_regfile_rsp.sv
// Directed self-checking bench for regfile_rsp (DEPTH=4).
// Expectations follow REGFILE_RSP_BYPASS_EN when it is defined for the build.
module tb_regfile_rsp;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic        stall;
  logic        wr_ready, busy, overflow;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef REGFILE_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_rsp #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .stall(stall), .wr_ready(wr_ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
    stall = 1'b0; rd_addr1 = 32'd0; rd_addr2 = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL reset_rd1: got %h want 0", rd_data1); end
    n_cmp++; if (rd_data2 !== 32'd0) begin n_fail++; $display("FAIL reset_rd2: got %h want 0", rd_data2); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_addi();
    logic [31:0] exp;
    do_reset();
    wr_en = 1'b1; wr_addr = 32'd48; wr_data = 32'd15; rd_addr1 = 32'd48;
    step();
    wr_en = 1'b0;
    exp = BYP ? 32'd15 : 32'd0;
    n_cmp++; if (rd_data1 !== exp) begin n_fail++; $display("FAIL addi_t1: got %0d want %0d", rd_data1, exp); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL addi_busy: got %b want 1", busy); end
    step();
    n_cmp++; if (rd_data1 !== exp) begin n_fail++; $display("FAIL addi_t2: got %0d want %0d", rd_data1, exp); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL addi_drained: got %b want 0", busy); end
    step();
    n_cmp++; if (rd_data1 !== 32'd15) begin n_fail++; $display("FAIL addi_t3: got %0d want 15", rd_data1); end
  endtask

  task automatic test_x0();
    do_reset();
    wr_en = 1'b1; wr_addr = 32'd0; wr_data = 32'hDEADBEEF; rd_addr1 = 32'd0; rd_addr2 = 32'd0;
    step();
    wr_en = 1'b0;
    n_cmp++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL x0_same_rd1: got %h want 0", rd_data1); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %b want 0", busy); end
    step();
    n_cmp++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL x0_rd1: got %h want 0", rd_data1); end
    n_cmp++; if (rd_data2 !== 32'd0) begin n_fail++; $display("FAIL x0_rd2: got %h want 0", rd_data2); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy2: got %b want 0", busy); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_addr = 32'(i * 4); wr_data = 32'(i);
      step();
      if (i == 3) begin
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready3: got %b want 1", wr_ready); end
      end
    end
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready4: got %b want 0", wr_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pre: got %b want 0", overflow); end
    wr_addr = 32'd20; wr_data = 32'd5;
    step();
    wr_en = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b want 1", overflow); end
    rd_addr1 = 32'd20;
    step();
    n_cmp++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL fill_x5: got %0d want 0", rd_data1); end
    stall = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_cmp++;
      if (busy !== (c < 4)) begin n_fail++; $display("FAIL fill_busy_c%0d: got %b want %b", c, busy, (c < 4)); end
    end
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after: got %b want 1", wr_ready); end
    for (int i = 1; i <= 4; i++) begin
      rd_addr1 = 32'(i * 4); rd_addr2 = 32'(i * 4);
      step();
      n_cmp++; if (rd_data1 !== 32'(i)) begin n_fail++; $display("FAIL fill_rd_x%0d: got %0d want %0d", i, rd_data1, i); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_youngest();
    logic [31:0] exp;
    do_reset();
    stall = 1'b1;
    wr_en = 1'b1; wr_addr = 32'd28; wr_data = 32'd10;
    step();
    wr_data = 32'd20;
    step();
    wr_en = 1'b0; rd_addr1 = 32'd28; rd_addr2 = 32'd28;
    step();
    exp = BYP ? 32'd20 : 32'd0;
    n_cmp++; if (rd_data1 !== exp) begin n_fail++; $display("FAIL young_pending: got %0d want %0d", rd_data1, exp); end
    stall = 1'b0;
    step(); step(); step();
    n_cmp++; if (rd_data1 !== 32'd20) begin n_fail++; $display("FAIL young_rd1: got %0d want 20", rd_data1); end
    n_cmp++; if (rd_data2 !== 32'd20) begin n_fail++; $display("FAIL young_rd2: got %0d want 20", rd_data2); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL young_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    stall = 1'b1;
    wr_en = 1'b1; wr_addr = 32'd36; wr_data = 32'd99;
    step();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmd_busy_pre: got %b want 1", busy); end
    reset = 1'b1; wr_addr = 32'd40; wr_data = 32'd5;
    step();
    reset = 1'b0; wr_en = 1'b0; stall = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmd_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmd_ovf: got %b want 0", overflow); end
    rd_addr1 = 32'd36; rd_addr2 = 32'd40;
    step(); step();
    n_cmp++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL rmd_x9: got %0d want 0", rd_data1); end
    n_cmp++; if (rd_data2 !== 32'd0) begin n_fail++; $display("FAIL rmd_x10: got %0d want 0", rd_data2); end
  endtask

  task automatic test_misaligned();
    do_reset();
    wr_en = 1'b1; wr_addr = 32'd50; wr_data = 32'd7; rd_addr1 = 32'd48;
    step();
    wr_en = 1'b0;
    n_cmp++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL mis_same: got %0d want 0", rd_data1); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mis_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mis_ovf: got %b want 0", overflow); end
    step(); step();
    n_cmp++; if (rd_data1 !== 32'd0) begin n_fail++; $display("FAIL mis_x12: got %0d want 0", rd_data1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    do_reset();
    // Upper address bits ignored; drain and new write at the same edge
    wr_en = 1'b1; wr_addr = 32'hFFFF_FF88; wr_data = 32'hA5A5_0001;
    step();
    wr_addr = 32'd12; wr_data = 32'h33; rd_addr1 = 32'd8; rd_addr2 = 32'h0000_0F8B;
    step();
    wr_en = 1'b0;
    exp = BYP ? 32'hA5A5_0001 : 32'd0;
    n_cmp++; if (rd_data1 !== exp) begin n_fail++; $display("FAIL b2b_x2: got %h want %h", rd_data1, exp); end
    n_cmp++; if (rd_data2 !== exp) begin n_fail++; $display("FAIL b2b_x2_alias: got %h want %h", rd_data2, exp); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
    step(); step();
    n_cmp++; if (rd_data1 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_x2_final: got %h want a5a50001", rd_data1); end
    rd_addr1 = 32'd12;
    step();
    n_cmp++; if (rd_data1 !== 32'h33) begin n_fail++; $display("FAIL b2b_x3_final: got %h want 33", rd_data1); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_addi();
    test_x0();
    test_fill_overflow();
    test_youngest();
    test_reset_mid_drain();
    test_misaligned();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
